// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states and RV32 funct3 codes.
package dmem_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/dmem_align_check.sv
// Combinational misalignment detector: words need addr[1:0]==0, halves need addr[0]==0.
module dmem_align_check #(
  parameter int DM_ADDRESS = 9
) (
  input  logic [2:0]            funct3_i,
  input  logic [DM_ADDRESS-1:0] addr_i,
  output logic                  misaligned_o
);

  assign misaligned_o = ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)) ||
                        ((funct3_i[1:0] == 2'b01) && addr_i[0]);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter, one access per two cycles (IDLE -> ACCESS -> IDLE).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
// Handshake: a request transfers on a rising edge where rN_valid && rN_ready; a requester
// holds valid and its request fields stable until that edge.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [DM_ADDRESS-1:0] r0_addr,
  input  logic [DATA_W-1:0]     r0_wdata,
  input  logic [2:0]            r0_funct3,
  output logic                  r0_rvalid,
  output logic [DATA_W-1:0]     r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [DM_ADDRESS-1:0] r1_addr,
  input  logic [DATA_W-1:0]     r1_wdata,
  input  logic [2:0]            r1_funct3,
  output logic                  r1_rvalid,
  output logic [DATA_W-1:0]     r1_rdata,
  output logic                  r1_err,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd,
  output state_e                state_o
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  id_q, id_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rid_q, rid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  gnt_id;
  logic                  hs;
  logic                  in_access;
  logic                  misaligned;

  // gnt_id names the winner whenever at least one requester is valid.
`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  assign gnt_id = (r0_valid && r1_valid) ? ptr_q : !r0_valid;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = ~gnt_id;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  assign gnt_id = !r0_valid;
`endif

  assign hs        = (state_q == ST_IDLE) && !reset && (r0_valid || r1_valid);
  assign r0_ready  = hs && !gnt_id;
  assign r1_ready  = hs && gnt_id;
  assign in_access = (state_q == ST_ACCESS);

  dmem_align_check #(.DM_ADDRESS(DM_ADDRESS)) u_align (
    .funct3_i     (funct3_q),
    .addr_i       (addr_q),
    .misaligned_o (misaligned)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    id_d     = id_q;
    rvalid_d = 1'b0;
    rid_d    = id_q;
    rdata_d  = '0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          state_d  = ST_ACCESS;
          we_d     = gnt_id ? r1_we     : r0_we;
          addr_d   = gnt_id ? r1_addr   : r0_addr;
          wdata_d  = gnt_id ? r1_wdata  : r0_wdata;
          funct3_d = gnt_id ? r1_funct3 : r0_funct3;
          id_d     = gnt_id;
        end
      end
      ST_ACCESS: begin
        state_d  = ST_IDLE;
        rvalid_d = 1'b1;
        err_d    = misaligned;
        if (!we_q && !misaligned) rdata_d = rd;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      id_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rid_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      id_q     <= id_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // A misaligned access still spends its ACCESS cycle but never strobes the memory.
  assign MemRead  = in_access && !we_q && !misaligned;
  assign MemWrite = in_access && we_q && !misaligned;
  assign a        = in_access ? addr_q   : '0;
  assign wd       = in_access ? wdata_q  : '0;
  assign Funct3   = in_access ? funct3_q : '0;

  assign r0_rvalid = rvalid_q && !rid_q;
  assign r1_rvalid = rvalid_q && rid_q;
  assign r0_rdata  = r0_rvalid ? rdata_q : '0;
  assign r1_rdata  = r1_rvalid ? rdata_q : '0;
  assign r0_err    = r0_rvalid && err_q;
  assign r1_err    = r1_rvalid && err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner sequences, random run vs model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    valid = '0;
  logic [1:0]    we = '0;
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wdata[2];
  logic [2:0]    f3[2];

  logic r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_err, r1_err;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic MemRead, MemWrite;
  logic [AW-1:0] a;
  logic [DW-1:0] wd, rd;
  logic [2:0] Funct3;
  state_e state_o;

  logic [1:0]    ready, rvalid, err;
  logic [DW-1:0] rdata_a[2];
  assign ready      = {r1_ready, r0_ready};
  assign rvalid     = {r1_rvalid, r0_rvalid};
  assign err        = {r1_err, r0_err};
  assign rdata_a[0] = r0_rdata;
  assign rdata_a[1] = r1_rdata;

  // Memory model: read data is a fixed function of the address unless overridden.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] ad);
    return {ad[7:0], ~ad[7:0], 7'h2A, ad};
  endfunction

  logic          ovr_en = 1'b0;
  logic [DW-1:0] ovr_val = '0;
  assign rd = ovr_en ? ovr_val : mem_fn(a);

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(valid[0]), .r0_ready(r0_ready), .r0_we(we[0]), .r0_addr(addr[0]),
    .r0_wdata(wdata[0]), .r0_funct3(f3[0]), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r0_err(r0_err),
    .r1_valid(valid[1]), .r1_ready(r1_ready), .r1_we(we[1]), .r1_addr(addr[1]),
    .r1_wdata(wdata[1]), .r1_funct3(f3[1]), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .r1_err(r1_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3), .rd(rd),
    .state_o(state_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit misal(input logic [2:0] f, input logic [AW-1:0] ad);
    case (f[1:0])
      2'b10:   return (ad % 4) != 0;
      2'b01:   return (ad % 2) != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit            id;
    bit            w;
    logic [AW-1:0] ad;
    logic [DW-1:0] wdv;
    logic [2:0]    f;
    logic [DW-1:0] rdv;
    bit            e_mr;
    bit            e_mw;
    logic [DW-1:0] e_rdata;
    bit            e_err;
  } vec_t;

  vec_t tbl[9];

  task automatic run_vec(input vec_t t);
    bit got;
    @(posedge clk); #1;
    ovr_en = 1'b1;
    ovr_val = t.rdv;
    valid[t.id] = 1'b1;
    we[t.id] = t.w;
    addr[t.id] = t.ad;
    wdata[t.id] = t.wdv;
    f3[t.id] = t.f;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (ready[t.id]) got = 1'b1;
    end
    chk("vec_handshake", got, 1);
    @(posedge clk); #1;
    valid[t.id] = 1'b0;
    @(negedge clk);
    chk("vec_memread", MemRead, t.e_mr);
    chk("vec_memwrite", MemWrite, t.e_mw);
    if (!t.e_err) begin
      chk("vec_a", a, t.ad);
      chk("vec_wd", wd, t.wdv);
      chk("vec_funct3", Funct3, t.f);
    end
    chk("vec_early_rvalid", rvalid, 0);
    @(negedge clk);
    chk("vec_rvalid", rvalid, 2'b01 << t.id);
    chk("vec_rdata", rdata_a[t.id], t.e_rdata);
    chk("vec_err", err, t.e_err ? (2'b01 << t.id) : 2'b00);
    chk("vec_other_rdata", rdata_a[t.id ? 0 : 1], 0);
    chk("vec_memread_off", MemRead | MemWrite, 0);
    ovr_en = 1'b0;
  endtask

  typedef struct {
    bit            w;
    logic [AW-1:0] ad;
    logic [DW-1:0] wdv;
    logic [2:0]    f;
  } req_t;

  function automatic req_t rand_req();
    req_t r;
    logic [2:0] ld_codes[5];
    ld_codes[0] = LB; ld_codes[1] = LH; ld_codes[2] = LW; ld_codes[3] = LBU; ld_codes[4] = LHU;
    r.w   = 1'($urandom_range(0, 1));
    r.f   = r.w ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
    r.ad  = AW'($urandom_range(0, (1 << AW) - 1));
    r.wdv = $urandom;
    return r;
  endfunction

  logic [0:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      addr[n] = '0; wdata[n] = '0; f3[n] = '0;
    end

    tbl[0] = '{1'b0, 1'b0, 9'h010, 32'h0,        LW,  32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 9'h020, 32'h12345678, SW,  32'hFFFF0000, 1'b0, 1'b1, 32'h0,        1'b0};
    tbl[2] = '{1'b0, 1'b0, 9'h013, 32'h0,        LW,  32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[3] = '{1'b1, 1'b0, 9'h012, 32'h0,        LH,  32'h0000BEEF, 1'b1, 1'b0, 32'h0000BEEF, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 9'h011, 32'hAAAA5555, SH,  32'h11111111, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[5] = '{1'b1, 1'b0, 9'h013, 32'h0,        LB,  32'h0000007F, 1'b1, 1'b0, 32'h0000007F, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 9'h016, 32'h0,        LHU, 32'h00008001, 1'b1, 1'b0, 32'h00008001, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 9'h1FF, 32'h000000EE, SB,  32'h22222222, 1'b0, 1'b1, 32'h0,        1'b0};
    tbl[8] = '{1'b0, 1'b1, 9'h1FE, 32'h0BADF00D, SW,  32'h33333333, 1'b0, 1'b0, 32'h0,        1'b1};

    // Reset with both requesters asserting valid: nothing may be accepted.
    reset = 1'b1;
    valid = 2'b11;
    @(negedge clk);
    chk("reset_ready", ready, 0);
    @(posedge clk); #1;
    valid = 2'b00;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", state_o, ST_IDLE);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_mem", {MemRead, MemWrite, Funct3}, 0);
    chk("reset_a", a, 0);
    chk("reset_rdata0", r0_rdata, 0);

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Both requesters valid continuously for four grants.
    do_reset();
`ifdef DMEM_ARB_RR_EN
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    we = 2'b00;
    addr[0] = 9'h040; f3[0] = LW;
    addr[1] = 9'h080; f3[1] = LW;
    valid = 2'b11;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      chk("arb_not_both", ready[0] & ready[1], 0);
      if (ready != 2'b00) chk("arb_grant", ready[1], exp_q.pop_front());
    end
    chk("arb_grant_count", exp_q.size(), 0);
    @(posedge clk); #1;
    valid = 2'b00;
    repeat (3) @(posedge clk);

    // Reset while an access is in flight.
    #1;
    valid[0] = 1'b1; we[0] = 1'b0; addr[0] = 9'h044; f3[0] = LW;
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(negedge clk);
        if (r0_ready) got = 1'b1;
      end
      chk("rst_mid_handshake", got, 1);
    end
    @(posedge clk); #1;
    valid = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_access", state_o, ST_ACCESS);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", state_o, ST_IDLE);
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_rdata0", r0_rdata, 0);
    chk("rst_mid_mem", {MemRead, MemWrite, Funct3}, 0);
    chk("rst_mid_a", a, 0);
    chk("rst_mid_ready", ready, 0);
    @(negedge clk);
    chk("rst_mid_no_late_rvalid", rvalid, 0);
    @(posedge clk); #1;
    valid = 2'b11;
    @(negedge clk);
    chk("rst_mid_ptr_zero", ready, 2'b01);
    @(posedge clk); #1;
    valid = 2'b00;
    repeat (3) @(posedge clk);

    // Valid held during a reset cycle is ignored.
    #1;
    reset = 1'b1;
    valid[1] = 1'b1; we[1] = 1'b0; addr[1] = 9'h008; f3[1] = LW;
    @(negedge clk);
    chk("rst_valid_ready", ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    valid = 2'b00;
    @(negedge clk);
    chk("rst_valid_no_access", state_o, ST_IDLE);
    chk("rst_valid_no_read", MemRead, 0);

    // Random traffic against a transaction-level model.
    do_reset();
    begin
      req_t          cur[2];
      req_t          acc_r;
      bit            acc_now, acc_id, rsp_now, rsp_id, rsp_err, favour, win, any;
      logic [DW-1:0] rsp_data;
      logic [1:0]    hs, exp_rdy;
      acc_now = 0; acc_id = 0; rsp_now = 0; rsp_id = 0; rsp_err = 0; favour = 0;
      rsp_data = '0; hs = '0;
      acc_r = '{1'b0, '0, '0, '0};
      for (int n = 0; n < 2; n++) cur[n] = '{1'b0, '0, '0, '0};
      for (int c = 0; c < 600; c++) begin
        @(posedge clk); #1;
        for (int n = 0; n < 2; n++) begin
          if (hs[n] || !valid[n]) begin
            if ($urandom_range(0, 3) != 0) begin
              cur[n] = rand_req();
              valid[n] = 1'b1;
              we[n] = cur[n].w; addr[n] = cur[n].ad; wdata[n] = cur[n].wdv; f3[n] = cur[n].f;
            end else begin
              valid[n] = 1'b0;
            end
          end
        end
        @(negedge clk);
        any = valid[0] || valid[1];
`ifdef DMEM_ARB_RR_EN
        win = (valid[0] && valid[1]) ? favour : !valid[0];
`else
        win = !valid[0];
`endif
        exp_rdy = (!acc_now && any) ? (2'b01 << win) : 2'b00;
        chk("rnd_ready", ready, exp_rdy);
        if (acc_now) begin
          bit m;
          m = misal(acc_r.f, acc_r.ad);
          chk("rnd_memread", MemRead, !acc_r.w && !m);
          chk("rnd_memwrite", MemWrite, acc_r.w && !m);
          if (!m) begin
            chk("rnd_a", a, acc_r.ad);
            chk("rnd_wd", wd, acc_r.wdv);
            chk("rnd_funct3", Funct3, acc_r.f);
          end
        end else begin
          chk("rnd_mem_idle", {MemRead, MemWrite, Funct3}, 0);
          chk("rnd_a_idle", a, 0);
          chk("rnd_wd_idle", wd, 0);
        end
        chk("rnd_rvalid", rvalid, rsp_now ? (2'b01 << rsp_id) : 2'b00);
        chk("rnd_err", err, (rsp_now && rsp_err) ? (2'b01 << rsp_id) : 2'b00);
        chk("rnd_rdata0", r0_rdata, (rsp_now && !rsp_id) ? rsp_data : '0);
        chk("rnd_rdata1", r1_rdata, (rsp_now && rsp_id) ? rsp_data : '0);

        rsp_now = acc_now;
        rsp_id = acc_id;
        rsp_err = acc_now && misal(acc_r.f, acc_r.ad);
        rsp_data = (acc_now && !acc_r.w && !rsp_err) ? mem_fn(acc_r.ad) : '0;
        hs = exp_rdy;
        acc_now = (hs != 2'b00);
        if (acc_now) begin
          acc_id = win;
          acc_r = cur[win];
          favour = !win;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
